// File: rtl/pcie_to_pc_fifo.sv
// Per-channel staging buffer between a user write stream and the PCIe TX engine.
// Words are collected into 512-byte blocks. Each slot is held until the TX engine reports it sent.
module pcie_to_pc_fifo (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] status,
   input  logic [1:0]  fifo_number,
   input  logic [63:0] i_data,
   input  logic        i_valid,
   output logic        i_ready,
   output logic        wr_valid,
   input  logic        wr_ready,
   output logic [7:0]  wr_tag,
   input  logic        wr_read,
   input  logic [2:0]  wr_read_block,
   input  logic [5:0]  wr_read_index,
   output logic [63:0] wr_data,
   input  logic        wr_done
);

   // Handshakes: a user word moves on a clock edge where i_valid and i_ready are
   // both high. A block is handed to the TX engine on an edge where wr_valid and
   // wr_ready are both high. wr_ready is ignored while wr_valid is low.

   logic [63:0] mem [0:511];

   logic [9:0]  p_write;
   logic [3:0]  p_send;
   logic [3:0]  p_free;
   logic [1:0]  holdoff;
   logic [22:0] sent_count;

   logic [9:0]  occupancy;
   logic [3:0]  unsent;
   logic        wr_en;
   logic        accept;
   logic        release_slot;

   always_comb begin
      occupancy    = p_write - {p_free, 6'd0};
      unsent       = p_write[9:6] - p_send;
      i_ready      = (occupancy < 10'd512);
      wr_valid     = (unsent != 4'd0) && (holdoff == 2'd0);
      wr_tag       = {fifo_number, 3'b000, p_send[2:0]};
      status       = {sent_count, 9'd0};
      wr_en        = i_valid && i_ready;
      accept       = wr_valid && wr_ready;
      release_slot = wr_done && (p_send != p_free);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         p_write    <= 10'd0;
         p_send     <= 4'd0;
         p_free     <= 4'd0;
         holdoff    <= 2'd0;
         sent_count <= 23'd0;
      end else begin
         if (wr_en) begin
            p_write <= p_write + 10'd1;
         end
         // The holdoff gap gives the TX engine time to latch the tag before the next offer.
         if (accept) begin
            p_send  <= p_send + 4'd1;
            holdoff <= 2'd3;
         end else if (holdoff != 2'd0) begin
            holdoff <= holdoff - 2'd1;
         end
         if (release_slot) begin
            p_free     <= p_free + 4'd1;
            sent_count <= sent_count + 23'd1;
         end
      end
   end

   // RAM has no reset, so contents and read data are undefined until written.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[p_write[8:0]] <= i_data;
      end
      if (wr_read) begin
         wr_data <= mem[{wr_read_block, wr_read_index}];
      end
   end

endmodule

// File: tb/tb_pcie_to_pc_fifo.sv
// Directed bench for pcie_to_pc_fifo: a vector table of block-level steps plus
// hand-written sequences for the fill, spacing, readback, status and reset cases.
module tb_pcie_to_pc_fifo;

   logic        clock;
   logic        reset;
   logic [31:0] status;
   logic [1:0]  fifo_number;
   logic [63:0] i_data;
   logic        i_valid;
   logic        i_ready;
   logic        wr_valid;
   logic        wr_ready;
   logic [7:0]  wr_tag;
   logic        wr_read;
   logic [2:0]  wr_read_block;
   logic [5:0]  wr_read_index;
   logic [63:0] wr_data;
   logic        wr_done;

   int checks;
   int errors;
   int data_ctr;

   pcie_to_pc_fifo dut (
      .clock         (clock),
      .reset         (reset),
      .status        (status),
      .fifo_number   (fifo_number),
      .i_data        (i_data),
      .i_valid       (i_valid),
      .i_ready       (i_ready),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .wr_tag        (wr_tag),
      .wr_read       (wr_read),
      .wr_read_block (wr_read_block),
      .wr_read_index (wr_read_index),
      .wr_data       (wr_data),
      .wr_done       (wr_done)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
      data_ctr = 0;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic write_words(input int n);
      for (int i = 0; i < n; i++) begin
         i_valid = 1'b1;
         i_data  = 64'(data_ctr);
         data_ctr++;
         step();
      end
      i_valid = 1'b0;
   endtask

   task automatic pulse_accept();
      wr_ready = 1'b1;
      step();
      wr_ready = 1'b0;
   endtask

   task automatic pulse_done();
      wr_done = 1'b1;
      step();
      wr_done = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic read_word(input logic [2:0] blk, input logic [5:0] idx);
      wr_read       = 1'b1;
      wr_read_block = blk;
      wr_read_index = idx;
      step();
      wr_read       = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!wr_valid && n < 20) begin
         step();
         n++;
      end
      if (!wr_valid) begin
         checks++;
         errors++;
         $display("FAIL %s: wr_valid never rose within 20 cycles, got 0, expected 1", name);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int          words;
      bit          acc;
      bit          done;
      logic [1:0]  fn;
      logic        exp_valid;
      logic        exp_ready;
      logic [7:0]  exp_tag;
      logic [31:0] exp_status;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int acc_cyc[2];
      int acc_low[2];
      int n_acc;

      checks = 0;
      errors = 0;
      data_ctr = 0;
      reset = 1'b0;
      fifo_number = 2'd0;
      i_data = '0;
      i_valid = 1'b0;
      wr_ready = 1'b0;
      wr_read = 1'b0;
      wr_read_block = '0;
      wr_read_index = '0;
      wr_done = 1'b0;

      // words, accept, done, fifo_number -> wr_valid, i_ready, wr_tag, status
      vecs[0] = '{63,  1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 8'h40, 32'd0};
      vecs[1] = '{1,   1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 8'h80, 32'd0};
      vecs[2] = '{0,   1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 8'hC1, 32'd0};
      vecs[3] = '{0,   1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 8'h01, 32'd512};
      vecs[4] = '{0,   1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 8'h01, 32'd512};
      vecs[5] = '{128, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 8'h81, 32'd512};
      vecs[6] = '{0,   1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 8'h82, 32'd512};
      vecs[7] = '{0,   1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 8'h83, 32'd1024};

      // Reset state
      fifo_number = 2'd3;
      do_reset();
      check("reset_i_ready", i_ready, 1);
      check("reset_wr_valid", wr_valid, 0);
      check("reset_status", status, 0);
      check("reset_wr_tag", wr_tag, 8'hC0);

      // Table-driven block steps
      for (int v = 0; v < 8; v++) begin
         fifo_number = vecs[v].fn;
         write_words(vecs[v].words);
         if (vecs[v].acc) pulse_accept();
         if (vecs[v].done) pulse_done();
         idle(4);
         check($sformatf("vec%0d_wr_valid", v), wr_valid, vecs[v].exp_valid);
         check($sformatf("vec%0d_i_ready", v), i_ready, vecs[v].exp_ready);
         check($sformatf("vec%0d_wr_tag", v), wr_tag, vecs[v].exp_tag);
         check($sformatf("vec%0d_status", v), status, vecs[v].exp_status);
      end

      // 63 words keep wr_valid low; the 64th raises it on the next cycle
      fifo_number = 2'd2;
      do_reset();
      for (int i = 0; i < 63; i++) begin
         write_words(1);
         check("partial_no_valid", wr_valid, 0);
      end
      write_words(1);
      check("block_valid", wr_valid, 1);
      check("block_tag", wr_tag, 8'h80);

      // Full buffer: 512 words, writes blocked, slot kept until wr_done
      fifo_number = 2'd1;
      do_reset();
      write_words(512);
      check("full_i_ready", i_ready, 0);
      check("full_wr_valid", wr_valid, 1);
      i_valid = 1'b1;
      i_data  = 64'd999;
      idle(2);
      i_valid = 1'b0;
      read_word(3'd0, 6'd0);
      check("full_no_overwrite", wr_data, 0);
      pulse_accept();
      idle(3);
      check("sent_not_freed_ready", i_ready, 0);
      pulse_done();
      check("freed_i_ready", i_ready, 1);
      check("freed_status", status, 512);
      i_valid = 1'b1;
      i_data  = 64'd12345;
      step();
      i_valid = 1'b0;
      read_word(3'd0, 6'd0);
      check("reuse_slot0_data", wr_data, 12345);
      check("occ449_i_ready", i_ready, 1);

      // Back-to-back accepts with wr_ready held: 4 cycles apart
      fifo_number = 2'd0;
      do_reset();
      write_words(128);
      n_acc = 0;
      wr_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (wr_valid && n_acc < 2) begin
            acc_cyc[n_acc] = c;
            acc_low[n_acc] = int'(wr_tag[2:0]);
            n_acc++;
         end
         step();
      end
      wr_ready = 1'b0;
      check("accept_count", n_acc, 2);
      if (n_acc == 2) begin
         check("accept_spacing", acc_cyc[1] - acc_cyc[0], 4);
         check("accept_tag0", acc_low[0], 0);
         check("accept_tag1", acc_low[1], 1);
      end

      // Readback from arbitrary slot/index
      do_reset();
      write_words(192);
      read_word(3'd2, 6'd5);
      check("read_b2_i5", wr_data, 133);
      idle(3);
      check("read_hold", wr_data, 133);
      read_word(3'd1, 6'd63);
      check("read_b1_i63", wr_data, 127);
      read_word(3'd0, 6'd0);
      check("read_b0_i0", wr_data, 0);

      // Eight sent and freed blocks, then a spurious wr_done
      do_reset();
      write_words(512);
      for (int b = 0; b < 8; b++) begin
         wait_valid("wait_block");
         pulse_accept();
      end
      idle(4);
      check("all_sent_no_valid", wr_valid, 0);
      for (int b = 0; b < 8; b++) pulse_done();
      check("status_8_blocks", status, 4096);
      check("all_freed_ready", i_ready, 1);
      pulse_done();
      check("status_extra_done", status, 4096);

      // Asynchronous reset with blocks buffered and in flight
      fifo_number = 2'd3;
      do_reset();
      write_words(256);
      pulse_accept();
      pulse_done();
      idle(3);
      pulse_accept();
      check("pre_reset_status", status, 512);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_wr_valid", wr_valid, 0);
      check("async_rst_i_ready", i_ready, 1);
      check("async_rst_status", status, 0);
      check("async_rst_tag", wr_tag, 8'hC0);
      step();
      reset = 1'b1;
      data_ctr = 0;
      step();
      write_words(63);
      check("post_rst_partial", wr_valid, 0);
      write_words(1);
      check("post_rst_valid", wr_valid, 1);
      check("post_rst_tag", wr_tag, 8'hC0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pcie_to_pc_fifo.md
PCIE_TO_PC_FIFO -- requirements
Module: pcie_to_pc_fifo

Interface
REQ-001 SHALL have one clock and one reset: clock; reset is asynchronous and active-low.
REQ-002 Port list (name direction width meaning), clock and reset first:
- clock  in  1  sole clock; all ports synchronous to it
- reset  in  1  asynchronous, active-low reset
- status  out  32  bytes sent to host
- fifo_number  in  2  tag high field for this channel
- i_data  in  64  user write data
- i_valid  in  1  i_data valid
- i_ready  out  1  buffer can accept a word
- wr_valid  out  1  a complete 512-byte block awaits a write request
- wr_ready  in  1  TX engine accepts the offered block
- wr_tag  out  8  tag of the offered block
- wr_read  in  1  TX engine reads one data word
- wr_read_block  in  3  block slot being read
- wr_read_index  in  6  word index within the slot
- wr_data  out  64  read data
- wr_done  in  1  oldest in-flight block fully transmitted; frees its slot

Function
REQ-003 SHALL contain a 512x64 reorder/staging RAM of 8 slots x 64 words; slot s spans addresses s*64..s*64+63.
REQ-004 SHALL keep a 10-bit word write pointer p_write, a 4-bit block send pointer p_send and a 4-bit block free pointer p_free, all wrapping modulo their width.
REQ-005 Occupancy SHALL be p_write - {p_free,6'd0} (10-bit modulo); i_ready SHALL be high when occupancy < 512.
REQ-006 On i_valid && i_ready SHALL write i_data to RAM address p_write[8:0] and increment p_write; otherwise no write.
REQ-007 Unsent complete blocks SHALL be p_write[9:6] - p_send (4-bit modulo); partial blocks are never offered.
REQ-008 wr_valid SHALL be high when unsent complete blocks >= 1 and holdoff == 0.
REQ-009 wr_tag SHALL equal {fifo_number, 3'b000, p_send[2:0]}.
REQ-010 On wr_valid && wr_ready SHALL increment p_send and load the 2-bit holdoff counter with 3; wr_ready while wr_valid is low SHALL be ignored.
REQ-011 Holdoff SHALL decrement by 1 per cycle while nonzero, so wr_valid stays low for at least 3 cycles after each acceptance.
REQ-012 On wr_read SHALL read RAM address {wr_read_block, wr_read_index}; wr_data SHALL present that word exactly 1 cycle later and hold its value while wr_read is low.
REQ-013 On wr_done with p_send != p_free SHALL increment p_free and increment a 23-bit sent-block counter; wr_done with p_send == p_free SHALL be ignored.
REQ-014 status SHALL equal {sent_block_count[22:0], 9'd0}; the counter wraps at 2^23.
REQ-015 Simultaneous input write, acceptance and wr_done in one cycle SHALL all take effect, each per its own rule.
REQ-016 A slot SHALL not be overwritten until freed by wr_done: at occupancy 512, i_ready is low even if slots have been sent but not freed.

Reset
REQ-017 Reset asserted SHALL immediately clear p_write, p_send, p_free, holdoff and the sent-block counter, regardless of clock.
REQ-018 During and directly after reset: i_ready=1, wr_valid=0, status=0, wr_tag={fifo_number,6'd0}; RAM contents and wr_data are don't-care.
REQ-019 Reset mid-transfer SHALL discard all buffered and in-flight blocks; no wr_valid until 64 new words are written.

Verification
REQ-020 Write 63 words -> wr_valid stays 0; 64th word -> wr_valid=1 next cycle, wr_tag={fifo_number,6'd0}.
REQ-021 Write 512 words with no wr_ready -> i_ready=0 after the 512th; one accept plus wr_done -> i_ready=1, occupancy 448.
REQ-022 Two complete blocks, wr_ready held high -> two accepts separated by exactly 4 cycles; tags low bits 0 then 1.
REQ-023 wr_read block 2 index 5 after writing 0..191 sequential data -> wr_data=133 one cycle later.
REQ-024 Eight wr_done pulses after eight sent blocks -> status=4096; extra wr_done with none in flight -> status unchanged.
REQ-025 Assert reset with 3 blocks buffered and 1 in flight -> wr_valid=0, i_ready=1, status=0 immediately; normal operation after release.
